// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned requests to instruction memory and
// buffers returned {pc, instr} pairs in a small FIFO feeding the IF/ID register.

`ifndef SYS_ADDR_SPACE
`define SYS_ADDR_SPACE 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module fetch_unit #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [`SYS_ADDR_SPACE-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       redirect_i,
    input  logic [`SYS_ADDR_SPACE-1:0] redirect_pc_i,
    output logic                       imem_req_o,
    output logic [`SYS_ADDR_SPACE-1:0] imem_addr_o,
    input  logic                       imem_gnt_i,
    input  logic                       imem_rvalid_i,
    input  logic [`INST_WIDTH-1:0]     imem_rdata_i,
    output logic                       valid_o,
    output logic [`INST_WIDTH-1:0]     instr_o,
    output logic [`SYS_ADDR_SPACE-1:0] pc_o,
    input  logic                       ready_i
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] DepthExt = FIFO_DEPTH[CntW:0];

    logic [`SYS_ADDR_SPACE-1:0] pc_q, pc_d;

    // Instruction buffer: head is read combinationally for the IF/ID register.
    logic [`SYS_ADDR_SPACE-1:0] buf_pc_q    [FIFO_DEPTH];
    logic [`INST_WIDTH-1:0]     buf_instr_q [FIFO_DEPTH];
    logic [PtrW-1:0]            buf_wr_q, buf_rd_q;
    logic [CntW-1:0]            count_q, count_d;

    // PC of every granted request, popped in order as responses return.
    logic [`SYS_ADDR_SPACE-1:0] tag_q [FIFO_DEPTH];
    logic [PtrW-1:0]            tag_wr_q, tag_rd_q;

    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] discard_q, discard_d;

    logic [CntW:0] inflight;
    logic          handshake;
    logic          resp_keep;
    logic          pop;

    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // The pop of this cycle is not credited, keeping ready_i off the request path.
    always_comb begin
        inflight    = {1'b0, count_q} + {1'b0, outstanding_q};
        imem_req_o  = !rst_i && !redirect_i && (inflight < DepthExt);
        imem_addr_o = pc_q;
        handshake   = imem_req_o && imem_gnt_i;
        resp_keep   = imem_rvalid_i && (discard_q == '0) && !redirect_i;
        valid_o     = (count_q != '0) && !redirect_i;
        pop         = valid_o && ready_i;
        instr_o     = buf_instr_q[buf_rd_q];
        pc_o        = buf_pc_q[buf_rd_q];
    end

    always_comb begin
        pc_d          = pc_q;
        count_d       = count_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CntW'(handshake) - CntW'(imem_rvalid_i);

        if (redirect_i) begin
            pc_d      = {redirect_pc_i[31:2], 2'b00};
            count_d   = '0;
            // A response landing in the redirect cycle is already stale.
            discard_d = outstanding_q - CntW'(imem_rvalid_i);
        end else begin
            if (handshake) begin
                pc_d = pc_q + 32'd4;
            end
            count_d = count_q + CntW'(resp_keep) - CntW'(pop);
            if (imem_rvalid_i && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q          <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            buf_wr_q      <= '0;
            buf_rd_q      <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_pc_q[i]    <= '0;
                buf_instr_q[i] <= '0;
                tag_q[i]       <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;

            if (handshake) begin
                tag_q[tag_wr_q] <= pc_q;
                tag_wr_q        <= tag_wr_q + 1'b1;
            end
            if (imem_rvalid_i) begin
                tag_rd_q <= tag_rd_q + 1'b1;
            end

            if (resp_keep) begin
                buf_pc_q[buf_wr_q]    <= tag_q[tag_rd_q];
                buf_instr_q[buf_wr_q] <= imem_rdata_i;
                buf_wr_q              <= buf_wr_q + 1'b1;
            end

            // No response is kept during a redirect, so the write pointer is final here.
            if (redirect_i) begin
                buf_rd_q <= buf_wr_q;
            end else if (pop) begin
                buf_rd_q <= buf_rd_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with configurable grant and latency,
// plus a second instance with a high reset PC to cover the address wrap.

module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready;

    logic        req2;
    logic [31:0] addr2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic        redirect2;
    logic [31:0] redirect_pc2;
    logic        gnt2;
    logic        ready2;

    int total;
    int bad;

    // Memory model controls: gnt_mode 0 = always, 1 = random, 2 = never.
    int   gnt_mode;
    int   lat_max;
    logic hold;
    logic gnt_rnd;
    int   cyc;
    int   grant_cnt;
    int   resp_cnt;

    typedef struct {
        logic [31:0] a;
        int          due;
    } mem_ent_t;
    mem_ent_t mq[$];
    mem_ent_t ent;
    int       lat_pick;

    fetch_unit #(
        .FIFO_DEPTH(4),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_req_o   (req),
        .imem_addr_o  (addr),
        .imem_gnt_i   (gnt),
        .imem_rvalid_i(rvalid),
        .imem_rdata_i (rdata),
        .valid_o      (valid),
        .instr_o      (instr),
        .pc_o         (pc),
        .ready_i      (ready)
    );

    fetch_unit #(
        .FIFO_DEPTH(4),
        .RESET_PC  (32'hFFFF_FFF8)
    ) dut_hi (
        .clk_i        (clk),
        .rst_i        (rst),
        .redirect_i   (redirect2),
        .redirect_pc_i(redirect_pc2),
        .imem_req_o   (req2),
        .imem_addr_o  (addr2),
        .imem_gnt_i   (gnt2),
        .imem_rvalid_i(rvalid2),
        .imem_rdata_i (rdata2),
        .valid_o      (valid2),
        .instr_o      (instr2),
        .pc_o         (pc2),
        .ready_i      (ready2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign gnt = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 2) ? 1'b0 : gnt_rnd;

    // In-order memory returning instr = address, each response lat cycles after its grant.
    always begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            mq.delete();
            grant_cnt = 0;
            resp_cnt  = 0;
        end else if (req && gnt) begin
            lat_pick = (lat_max <= 1) ? 1 : int'($urandom_range(1, lat_max));
            ent.a    = addr;
            ent.due  = cyc + lat_pick - 1;
            mq.push_back(ent);
            grant_cnt++;
        end
        #1;
        rvalid = 1'b0;
        if (!rst && !hold && mq.size() > 0 && mq[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = mq[0].a;
            mq.pop_front();
            resp_cnt++;
        end
        gnt_rnd = 1'($urandom_range(0, 1));
    end

    // Zero-wait memory for the high-reset-PC instance.
    logic        hs2;
    logic [31:0] a2;
    always begin
        @(posedge clk);
        hs2 = req2 && gnt2 && !rst;
        a2  = addr2;
        #1;
        rvalid2 = hs2;
        rdata2  = a2;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (req !== 1'b0 || valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: req=%b valid=%b pc=%h instr=%h, required 0 0 0 0",
                     req, valid, pc, instr);
        end
    endtask

    task automatic test_stream();
        gnt_mode = 0; lat_max = 1; hold = 1'b0; ready = 1'b1;
        do_reset();
        total++;
        if (req !== 1'b1 || addr !== 32'h0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_first_req: req=%b addr=%h valid=%b, required 1 0 0",
                     req, addr, valid);
        end
        @(negedge clk); #1;
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_cycle2_valid: got %b, required 0", valid);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            total++;
            if (valid !== 1'b1 || pc !== 32'(4 * k) || instr !== 32'(4 * k)) begin
                bad++;
                $display("FAIL stream_word%0d: valid=%b pc=%h instr=%h, required 1 %h %h",
                         k, valid, pc, instr, 32'(4 * k), 32'(4 * k));
            end
        end
    endtask

    task automatic test_ready_low();
        gnt_mode = 0; lat_max = 1; hold = 1'b0; ready = 1'b0;
        do_reset();
        @(negedge clk);
        for (int k = 3; k <= 12; k++) begin
            @(negedge clk); #1;
            total++;
            if (valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h0) begin
                bad++;
                $display("FAIL stall_hold_c%0d: valid=%b pc=%h instr=%h, required 1 0 0",
                         k, valid, pc, instr);
            end
        end
        total++;
        if (grant_cnt !== 4) begin
            bad++;
            $display("FAIL stall_grants: got %0d, required 4", grant_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ready = 1'b1;
            #1;
            total++;
            if (valid !== 1'b1 || pc !== 32'(4 * k) || instr !== 32'(4 * k)) begin
                bad++;
                $display("FAIL stall_drain%0d: valid=%b pc=%h instr=%h, required 1 %h %h",
                         k, valid, pc, instr, 32'(4 * k), 32'(4 * k));
            end
        end
    endtask

    task automatic test_variable_latency();
        logic [31:0] exp_pc;
        int          delivered;
        gnt_mode = 1; lat_max = 3; hold = 1'b0; ready = 1'b1;
        exp_pc    = 32'h0;
        delivered = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            ready = 1'($urandom_range(0, 1));
            #1;
            if (valid && ready) begin
                total++;
                if (pc !== exp_pc || instr !== exp_pc) begin
                    bad++;
                    $display("FAIL varlat_stream: pc=%h instr=%h, required %h %h",
                             pc, instr, exp_pc, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (grant_cnt - resp_cnt > 4) begin
                total++;
                bad++;
                $display("FAIL varlat_outstanding: got %0d, required <= 4",
                         grant_cnt - resp_cnt);
            end
        end
        total++;
        if (delivered < 40) begin
            bad++;
            $display("FAIL varlat_progress: delivered %0d, required >= 40", delivered);
        end
        ready = 1'b1;
        gnt_mode = 0;
        lat_max = 1;
    endtask

    task automatic test_redirect_flush();
        bit found;
        gnt_mode = 0; lat_max = 1; hold = 1'b0; ready = 1'b0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        hold = 1'b1;
        @(negedge clk); #1;
        total++;
        if (req !== 1'b1 || addr !== 32'hC) begin
            bad++;
            $display("FAIL redir_setup_req: req=%b addr=%h, required 1 0000000c", req, addr);
        end
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        ready = 1'b1;
        #1;
        total++;
        if (valid !== 1'b0 || req !== 1'b0) begin
            bad++;
            $display("FAIL redir_cycle: valid=%b req=%b, required 0 0", valid, req);
        end
        @(negedge clk);
        redirect = 1'b0;
        hold = 1'b0;
        #1;
        total++;
        if (req !== 1'b1 || addr !== 32'h100 || valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_new_req: req=%b addr=%h valid=%b, required 1 00000100 0",
                     req, addr, valid);
        end
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            @(negedge clk); #1;
            if (valid) found = 1'b1;
        end
        total++;
        if (!found || pc !== 32'h100 || instr !== 32'h100) begin
            bad++;
            $display("FAIL redir_first: found=%b pc=%h instr=%h, required 1 00000100 00000100",
                     found, pc, instr);
        end
        @(negedge clk); #1;
        total++;
        if (valid !== 1'b1 || pc !== 32'h104) begin
            bad++;
            $display("FAIL redir_second: valid=%b pc=%h, required 1 00000104", valid, pc);
        end
    endtask

    task automatic test_redirect_unaligned();
        gnt_mode = 0; lat_max = 1; hold = 1'b0; ready = 1'b1;
        do_reset();
        repeat (6) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h203;
        #1;
        total++;
        if (valid !== 1'b0 || req !== 1'b0) begin
            bad++;
            $display("FAIL unal_redir_cycle: valid=%b req=%b, required 0 0", valid, req);
        end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        total++;
        if (req !== 1'b1 || addr !== 32'h200 || valid !== 1'b0) begin
            bad++;
            $display("FAIL unal_new_req: req=%b addr=%h valid=%b, required 1 00000200 0",
                     req, addr, valid);
        end
        @(negedge clk); #1;
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL unal_dropped: valid=%b pc=%h, required valid 0", valid, pc);
        end
        @(negedge clk); #1;
        total++;
        if (valid !== 1'b1 || pc !== 32'h200 || instr !== 32'h200) begin
            bad++;
            $display("FAIL unal_first: valid=%b pc=%h instr=%h, required 1 00000200 00000200",
                     valid, pc, instr);
        end
    endtask

    task automatic test_reset_pc_wrap();
        logic [31:0] exp_pcs [3];
        exp_pcs[0] = 32'hFFFF_FFF8;
        exp_pcs[1] = 32'hFFFF_FFFC;
        exp_pcs[2] = 32'h0000_0000;
        do_reset();
        total++;
        if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFF8) begin
            bad++;
            $display("FAIL wrap_first_req: req=%b addr=%h, required 1 fffffff8", req2, addr2);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            total++;
            if (valid2 !== 1'b1 || pc2 !== exp_pcs[k] || instr2 !== exp_pcs[k]) begin
                bad++;
                $display("FAIL wrap_word%0d: valid=%b pc=%h instr=%h, required 1 %h %h",
                         k, valid2, pc2, instr2, exp_pcs[k], exp_pcs[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        gnt_mode = 0; lat_max = 1; hold = 1'b0; ready = 1'b1;
        do_reset();
        repeat (6) @(negedge clk);
        #1;
        total++;
        if (valid !== 1'b1 || pc !== 32'h10) begin
            bad++;
            $display("FAIL arst_pre: valid=%b pc=%h, required 1 00000010", valid, pc);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 || req !== 1'b0) begin
            bad++;
            $display("FAIL arst_zero: valid=%b pc=%h instr=%h req=%b, required 0 0 0 0",
                     valid, pc, instr, req);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (req !== 1'b1 || addr !== 32'h0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL arst_restart: req=%b addr=%h valid=%b, required 1 0 0",
                     req, addr, valid);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            total++;
            if (valid !== 1'b1 || pc !== 32'(4 * k)) begin
                bad++;
                $display("FAIL arst_word%0d: valid=%b pc=%h, required 1 %h",
                         k, valid, pc, 32'(4 * k));
            end
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        ready        = 1'b1;
        gnt_mode     = 0;
        lat_max      = 1;
        hold         = 1'b0;
        gnt_rnd      = 1'b1;
        cyc          = 0;
        grant_cnt    = 0;
        resp_cnt     = 0;
        rvalid       = 1'b0;
        rdata        = 32'h0;
        rvalid2      = 1'b0;
        rdata2       = 32'h0;
        redirect2    = 1'b0;
        redirect_pc2 = 32'h0;
        gnt2         = 1'b1;
        ready2       = 1'b1;

        test_reset();
        test_stream();
        test_ready_low();
        test_variable_latency();
        test_redirect_flush();
        test_redirect_unaligned();
        test_reset_pc_wrap();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the in-order RISC-V core. It owns the program counter and issues word-aligned requests to instruction memory over a request/grant and response-valid handshake. Returned instructions, tagged with their PCs, are buffered in a small FIFO that feeds the IF_ID pipeline register, whose contents the ID stage decodes. Control-flow redirects from EXE flush in-flight and buffered fetches.

## Interface
- FIFO_DEPTH, 4, fetch buffer entries; power of two, ≥2; also the bound on outstanding requests.
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- redirect_i  in  1  EXE branch/jump taken; flush and restart fetch.
- redirect_pc_i  in  `SYS_ADDR_SPACE  new PC; bits [1:0] are ignored and treated as 0.
- imem_req_o  out  1  request valid.
- imem_addr_o  out  `SYS_ADDR_SPACE  request address (current PC).
- imem_gnt_i  in  1  request accepted this cycle (req & gnt = handshake).
- imem_rvalid_i  in  1  response valid; responses return in request order, ≥1 cycle after grant.
- imem_rdata_i  in  `INST_WIDTH  instruction word.
- valid_o  out  1  FIFO head valid toward IF_ID.
- instr_o  out  `INST_WIDTH  head instruction.
- pc_o  out  `SYS_ADDR_SPACE  PC of head instruction.
- ready_i  in  1  IF_ID accepts head (ID not stalled).

## Operation
- State: pc, instruction FIFO {pc, instr} with count, outstanding counter (0..FIFO_DEPTH), pc tag queue (FIFO_DEPTH entries, PC of each granted request), discard counter.
- Issue: imem_req_o = !rst_i & !redirect_i & (count + outstanding < FIFO_DEPTH). imem_addr_o = pc. The pop in the current cycle is not credited, so ready_i has no combinational path to imem_req_o.
- On req & gnt: pc <= pc + 4 (32-bit wrap; 32'hFFFF_FFFC → 0). Push pc onto the tag queue. outstanding++.
- On rvalid with discard == 0: pop the tag queue, push {tag, rdata} into the FIFO, and decrement outstanding.
- On rvalid with discard > 0: drop the data, pop the tag queue, and decrement discard and outstanding.
- Grant and response in the same cycle: outstanding is unchanged; both queues update.
- Output: valid_o = (count != 0) & !redirect_i. instr_o and pc_o show the FIFO head. They are held stable while valid_o & !ready_i.
- Pop when valid_o & ready_i.
- Redirect (priority over everything):
  - FIFO count <= 0.
  - pc <= {redirect_pc_i[31:2], 2'b00}.
  - discard <= outstanding minus any response arriving this cycle. That response is dropped.
  - No request is issued in the redirect cycle.
- Responses never overflow the FIFO, because credit is reserved at grant time. A response while the FIFO is full cannot occur with a legal memory.

## Timing
- Reset (async assert): pc = RESET_PC; count, outstanding, and discard = 0; imem_req_o = 0; valid_o = 0; instr_o = 0; pc_o = 0.
- First request is issued in the first clock cycle after rst_i deasserts, with imem_addr_o = RESET_PC.
- Zero-wait memory (gnt same cycle, rvalid next cycle):
  - Request in cycle N, response in N+1, valid_o high in N+2. Fetch latency is 2 cycles.
  - With FIFO_DEPTH ≥ 3 and ready_i held high, throughput is one instruction per cycle.
- Redirect in cycle R: valid_o is low in R. The new request, at redirect_pc, is issued in R+1. Its instruction appears at valid_o in R+3 at the earliest.
- Reset mid-transfer: all counters clear. Responses to pre-reset requests must not be delivered by the memory; the memory resets on the same rst_i.
- Redirect while discard > 0: discard is reloaded from the current outstanding count, which already includes the earlier stale requests.

## Test plan
- Reset release, zero-wait memory, ready_i = 1, instruction = address: pc_o = 0, 4, 8, … on consecutive cycles from the 2nd cycle after reset; instr_o matches; no bubbles.
- ready_i = 0 for 10 cycles: at most 4 requests are granted. valid_o stays high with the head held at pc 0. On release, pc 0, 4, 8, 12 drain in order with no loss.
- Variable-latency memory (gnt random 50%, rvalid 1–3 cycles late): output PC stream is strictly +4 with no duplicates or drops. outstanding never exceeds FIFO_DEPTH.
- Redirect to 0x100 while 2 requests are outstanding and 2 entries are buffered: valid_o is low in the redirect cycle. The 2 stale responses are dropped. The next delivered pc_o is 0x100, then 0x104.
- Redirect to 0x203: fetch resumes at 0x200. Redirect coincident with a response and a pop: the response is dropped and no entry is delivered.
- RESET_PC = 32'hFFFF_FFF8: delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000. Async rst_i pulse mid-stream: outputs are zeroed immediately and fetch restarts at RESET_PC.
